scalar_product_mac: RTL and testbench
=====================================

# scalar_product_mac

Sequential, parametrised successor to the combinational `scalar_product`. It computes the dot product of two packed vectors of `Ndata` elements of `Nbits` each. Each cycle it processes `Nlanes` element pairs, and it supports signed or unsigned operands, a configurable result width, and valid/ready handshakes on both sides. It sits between operand buffers and the matrix-multiply result path, and is the building block for one output element of `matmul`.

## Interface
- `Nbits`, 4: element width.
- `Ndata`, 4: elements per vector. Must be a multiple of `Nlanes`; any other value is an elaboration error.
- `Nlanes`, 1: multipliers working in parallel. NCHUNK = `Ndata`/`Nlanes`.
- `Signed`, 0: 0 treats operands as unsigned, 1 as two's complement.
- `Nout`, 2*`Nbits`+clog2(`Ndata`): result width. With `Nout`=2*`Nbits` the result matches legacy `scalar_product` (mod 2^(2·`Nbits`)).
- `clk`  in  1: single clock. All state changes on the rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `A`  in  `Ndata`*`Nbits`: vector A. Element i is at bits [i*`Nbits` +: `Nbits`].
- `B`  in  `Ndata`*`Nbits`: vector B, same packing as A.
- `in_valid`  in  1: A and B are valid.
- `in_ready`  out  1: block can accept a new vector pair.
- `out`  out  `Nout`: result.
- `out_valid`  out  1: `out` is valid.
- `out_ready`  in  1: consumer accepts `out`.

## Operation
- Three states: IDLE, BUSY, DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`&&`in_ready`: register A and B, clear the accumulator, clear the chunk counter, go to BUSY.
- BUSY, one edge per chunk c:
  - acc += sum over lanes l of A[c*`Nlanes`+l] × B[c*`Nlanes`+l].
  - Element 0 is processed first.
  - On the last chunk, load the final sum into the `out` register and go to DONE.
- DONE:
  - `out_valid`=1 and `out` is held stable.
  - On `out_valid`&&`out_ready`: go to IDLE.
- Arithmetic:
  - Products are 2*`Nbits` bits, sign- or zero-extended per `Signed`.
  - The accumulator is exact, 2*`Nbits`+clog2(`Ndata`) bits wide.
  - `out` is the low `Nout` bits of the exact sum (wrap, no saturation). If `Nout` is wider than the accumulator, `out` is extended per `Signed`.
- `in_valid` in BUSY or DONE is ignored. The source must hold its data until it sees `in_ready`.
- A and B are sampled only at acceptance. Changes to A or B during BUSY have no effect.

## Timing
- Reset values: state=IDLE, acc=0, counter=0, `out`=0, `out_valid`=0.
- `in_ready` is a decode of state==IDLE and !`rst`, so it is 0 while `rst` is high.
- Latency: acceptance at edge t0 gives `out_valid`=1 after edge t0+NCHUNK.
- Throughput: best case one result every NCHUNK+2 cycles (`in_ready` returns the cycle after the output transfer).
- `Nlanes`=`Ndata` gives NCHUNK=1: `out_valid` one cycle after acceptance.
- Backpressure: while `out_ready`=0 in DONE, `out` and `out_valid` are held indefinitely and `in_ready`=0.
- `rst` mid-operation (BUSY or DONE):
  - At the next edge the block returns to IDLE.
  - The partial result is discarded and `out_valid` drops.
  - No spurious output transfer occurs.
- `out_ready` sampled outside DONE has no effect.

## Structure
- `scalar_product_pkg` holds:
  - the state encoding (IDLE/BUSY/DONE);
  - a clog2 function;
  - accumulator and default `Nout` width helpers;
  - the `Ndata` % `Nlanes` check.
- Sub-module `mac_lane`: one `Nbits`×`Nbits` multiplier, signed or unsigned per `Signed`, with a 2*`Nbits` output.
  - `Nlanes` instances feed a combinational adder tree into the accumulator.
- The top level holds the FSM, chunk counter, operand registers, accumulator and output register.

## Test plan
- Basic unsigned (`Nbits`=4, `Ndata`=4, `Nlanes`=1): A=16'h4321, B=16'h1111 -> `out`=10'h00A, `out_valid` rises 4 edges after acceptance, `in_ready` returns 1 cycle after the transfer.
- Width and wrap: A=B=16'hFFFF -> `out`=10'h384 (900); the same stimulus with `Nout`=8 -> 8'h84, matching legacy `scalar_product`.
- Signed (`Signed`=1): A=16'hFFFF (all -1), B=16'h7777 -> `out`=10'h3E4 (-28).
- Backpressure:
  - Hold `out_ready`=0 for 5 cycles in DONE -> `out` stable, `out_valid`=1, `in_ready`=0.
  - A new `in_valid` with changed A and B is ignored until the transfer completes.
- Reset mid-BUSY: assert `rst` 2 cycles after acceptance -> next edge IDLE, `out`=0, `out_valid`=0; a fresh operation afterwards gives the correct result.
- Parallel mode (`Nlanes`=4): the same vectors as the basic case -> `out`=10'h00A, `out_valid` 1 edge after acceptance. Also run 100 random vectors back-to-back against a reference model with random `out_ready`.

Source files
------------

// File: rtl/scalar_product_pkg.sv
// Shared definitions for the sequential dot-product engine: FSM encoding and
// the width helpers used to size the accumulator, counter and result.
package scalar_product_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } sp_state_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int w = 1; w < value; w = w * 2) begin
      result++;
    end
    return result;
  endfunction

  function automatic int prod_width(input int nbits);
    return 2 * nbits;
  endfunction

  // Wide enough to hold the exact sum of ndata full-width products.
  function automatic int acc_width(input int nbits, input int ndata);
    return prod_width(nbits) + clog2(ndata);
  endfunction

  function automatic int default_nout(input int nbits, input int ndata);
    return acc_width(nbits, ndata);
  endfunction

  function automatic int ctr_width(input int nchunk);
    return (nchunk > 1) ? clog2(nchunk) : 1;
  endfunction

  function automatic bit lanes_divide(input int ndata, input int nlanes);
    return (nlanes > 0) && (ndata >= nlanes) && ((ndata % nlanes) == 0);
  endfunction

endpackage

// File: rtl/mac_lane.sv
// One Nbits x Nbits multiplier lane; operands are widened per Signed so a
// plain 2*Nbits multiply yields the correct product in either mode.
module mac_lane
  import scalar_product_pkg::*;
#(
  parameter int Nbits  = 4,
  parameter bit Signed = 1'b0
) (
  input  logic [Nbits-1:0]             i_a,
  input  logic [Nbits-1:0]             i_b,
  output logic [prod_width(Nbits)-1:0] o_prod
);

  localparam int PRODW = prod_width(Nbits);

  logic [PRODW-1:0] w_a_ext;
  logic [PRODW-1:0] w_b_ext;

  generate
    if (Signed) begin : g_signed
      assign w_a_ext = {{Nbits{i_a[Nbits-1]}}, i_a};
      assign w_b_ext = {{Nbits{i_b[Nbits-1]}}, i_b};
    end else begin : g_unsigned
      assign w_a_ext = {{Nbits{1'b0}}, i_a};
      assign w_b_ext = {{Nbits{1'b0}}, i_b};
    end
  endgenerate

  // Truncating to 2*Nbits is exact for two's complement as well.
  assign o_prod = w_a_ext * w_b_ext;

endmodule

// File: rtl/scalar_product_mac.sv
// Sequential dot product: Nlanes element pairs per cycle, exact accumulator,
// valid/ready on input and output, result held until the consumer takes it.
module scalar_product_mac
  import scalar_product_pkg::*;
#(
  parameter int Nbits  = 4,
  parameter int Ndata  = 4,
  parameter int Nlanes = 1,
  parameter bit Signed = 1'b0,
  parameter int Nout   = default_nout(Nbits, Ndata)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [Ndata*Nbits-1:0] A,
  input  logic [Ndata*Nbits-1:0] B,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [Nout-1:0]        out,
  output logic                   out_valid,
  input  logic                   out_ready
);

  localparam int NCHUNK      = Ndata / Nlanes;
  localparam int PRODW       = prod_width(Nbits);
  localparam int ACCW        = acc_width(Nbits, Ndata);
  localparam int CNTW        = ctr_width(NCHUNK);
  localparam int VECW        = Ndata * Nbits;
  localparam int STEPW       = Nlanes * Nbits;
  localparam int TREE_DEPTH  = clog2(Nlanes);
  localparam int TREE_LEAVES = 1 << TREE_DEPTH;
  localparam logic [CNTW-1:0] LAST_CHUNK = CNTW'(NCHUNK - 1);

  generate
    if (!lanes_divide(Ndata, Nlanes)) begin : g_cfg_error
      $error("scalar_product_mac: Ndata must be a positive multiple of Nlanes");
    end
  endgenerate

  sp_state_t r_state;
  sp_state_t w_state_next;

  logic [VECW-1:0] r_a;
  logic [VECW-1:0] r_b;
  logic [ACCW-1:0] r_acc;
  logic [CNTW-1:0] r_chunk;
  logic [Nout-1:0] r_out;

  logic            w_accept;
  logic            w_last;
  logic [ACCW-1:0] w_chunk_sum;
  logic [ACCW-1:0] w_acc_sum;
  logic [Nout-1:0] w_out_next;
  logic [PRODW-1:0] w_prod [Nlanes];

  // ---------------------------------------------------------------- lanes
  // Operands shift down one chunk per cycle, so lane gi always sees the
  // low slots; element 0 is consumed first.
  generate
    for (genvar gi = 0; gi < Nlanes; gi++) begin : g_lane
      mac_lane #(
        .Nbits  (Nbits),
        .Signed (Signed)
      ) u_lane (
        .i_a    (r_a[gi*Nbits +: Nbits]),
        .i_b    (r_b[gi*Nbits +: Nbits]),
        .o_prod (w_prod[gi])
      );
    end
  endgenerate

  // Balanced adder tree, padded with zero leaves up to a power of two.
  generate
    for (genvar gl = 0; gl <= TREE_DEPTH; gl++) begin : g_level
      localparam int NODES = TREE_LEAVES >> gl;
      logic [NODES-1:0][ACCW-1:0] w_node;
      if (gl == 0) begin : g_leaf
        for (genvar gi = 0; gi < NODES; gi++) begin : g_slot
          if (gi >= Nlanes) begin : g_pad
            assign w_node[gi] = '0;
          end else if (Signed) begin : g_sext
            assign w_node[gi] = ACCW'($signed(w_prod[gi]));
          end else begin : g_zext
            assign w_node[gi] = ACCW'(w_prod[gi]);
          end
        end
      end else begin : g_add
        for (genvar gi = 0; gi < NODES; gi++) begin : g_pair
          assign w_node[gi] = g_level[gl-1].w_node[2*gi] + g_level[gl-1].w_node[2*gi+1];
        end
      end
    end
  endgenerate

  assign w_chunk_sum = g_level[TREE_DEPTH].w_node[0];
  assign w_acc_sum   = r_acc + w_chunk_sum;

  generate
    if (Nout <= ACCW) begin : g_out_wrap
      assign w_out_next = w_acc_sum[Nout-1:0];
    end else if (Signed) begin : g_out_sext
      assign w_out_next = Nout'($signed(w_acc_sum));
    end else begin : g_out_zext
      assign w_out_next = Nout'(w_acc_sum);
    end
  endgenerate

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (in_valid) w_state_next = ST_BUSY;
      ST_BUSY: if (r_chunk == LAST_CHUNK) w_state_next = ST_DONE;
      ST_DONE: if (out_ready) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == ST_IDLE) && !rst;
    out_valid = (r_state == ST_DONE);
  end

  assign w_accept = in_valid && in_ready;
  assign w_last   = (r_state == ST_BUSY) && (r_chunk == LAST_CHUNK);

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_chunk <= '0;
      r_out   <= '0;
    end else if (w_accept) begin
      r_a     <= A;
      r_b     <= B;
      r_acc   <= '0;
      r_chunk <= '0;
    end else if (r_state == ST_BUSY) begin
      r_a     <= r_a >> STEPW;
      r_b     <= r_b >> STEPW;
      r_acc   <= w_acc_sum;
      r_chunk <= r_chunk + 1'b1;
      if (w_last) begin
        r_out <= w_out_next;
      end
    end
  end

  assign out = r_out;

endmodule

// File: tb/tb_scalar_product_mac.sv
// Bench for scalar_product_mac: four configurations (basic, Nout=8, signed,
// four lanes) checked against a plain-arithmetic dot-product model.
module tb_scalar_product_mac;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [15:0] a_s [4];
  logic [15:0] b_s [4];
  logic [3:0]  in_valid_s;
  logic [3:0]  in_ready_s;
  logic [3:0]  out_valid_s;
  logic [3:0]  out_ready_s;
  logic [9:0]  out0;
  logic [7:0]  out1;
  logic [9:0]  out2;
  logic [9:0]  out3;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int exp_q [4][$];
  bit [3:0] rand_done;

  always @(posedge clk) cyc <= cyc + 1;

  scalar_product_mac u_basic (
    .clk(clk), .rst(rst), .A(a_s[0]), .B(b_s[0]),
    .in_valid(in_valid_s[0]), .in_ready(in_ready_s[0]),
    .out(out0), .out_valid(out_valid_s[0]), .out_ready(out_ready_s[0])
  );

  scalar_product_mac #(.Nout(8)) u_narrow (
    .clk(clk), .rst(rst), .A(a_s[1]), .B(b_s[1]),
    .in_valid(in_valid_s[1]), .in_ready(in_ready_s[1]),
    .out(out1), .out_valid(out_valid_s[1]), .out_ready(out_ready_s[1])
  );

  scalar_product_mac #(.Signed(1'b1)) u_signed (
    .clk(clk), .rst(rst), .A(a_s[2]), .B(b_s[2]),
    .in_valid(in_valid_s[2]), .in_ready(in_ready_s[2]),
    .out(out2), .out_valid(out_valid_s[2]), .out_ready(out_ready_s[2])
  );

  scalar_product_mac #(.Nlanes(4)) u_par (
    .clk(clk), .rst(rst), .A(a_s[3]), .B(b_s[3]),
    .in_valid(in_valid_s[3]), .in_ready(in_ready_s[3]),
    .out(out3), .out_valid(out_valid_s[3]), .out_ready(out_ready_s[3])
  );

  function automatic int out_of(input int k);
    case (k)
      0:       return int'(out0);
      1:       return int'(out1);
      2:       return int'(out2);
      default: return int'(out3);
    endcase
  endfunction

  function automatic bit sgn_of(input int k);
    return k == 2;
  endfunction

  function automatic int nout_of(input int k);
    return (k == 1) ? 8 : 10;
  endfunction

  // Dot product of four 4-bit elements, reduced modulo 2^nb.
  function automatic int ref_dot(input logic [15:0] a, input logic [15:0] b,
                                 input bit sg, input int nb);
    int s;
    int ea;
    int eb;
    s = 0;
    for (int i = 0; i < 4; i++) begin
      ea = int'(a[i*4 +: 4]);
      eb = int'(b[i*4 +: 4]);
      if (sg && ea > 7) ea -= 16;
      if (sg && eb > 7) eb -= 16;
      s += ea * eb;
    end
    return s & ((1 << nb) - 1);
  endfunction

  task automatic chk(input string tag, input int got, input int want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Call at a falling edge; returns at the falling edge after acceptance.
  task automatic send(input int k, input logic [15:0] a, input logic [15:0] b,
                      output int acc_cyc);
    acc_cyc        = -1;
    a_s[k]         = a;
    b_s[k]         = b;
    in_valid_s[k]  = 1'b1;
    for (int n = 0; n < 400; n++) begin
      #1;
      if (in_ready_s[k]) begin
        exp_q[k].push_back(ref_dot(a, b, sgn_of(k), nout_of(k)));
        @(negedge clk);
        acc_cyc       = cyc;
        in_valid_s[k] = 1'b0;
        $display("send k=%0d A=%h B=%h accepted cyc=%0d", k, a, b, acc_cyc);
        return;
      end
      @(negedge clk);
    end
    in_valid_s[k] = 1'b0;
    chk($sformatf("accept_timeout%0d", k), 0, 1);
  endtask

  task automatic wait_valid(input int k, input int acc_cyc, output int lat);
    lat = -1;
    for (int n = 0; n < 400; n++) begin
      if (out_valid_s[k]) begin
        lat = cyc - acc_cyc;
        return;
      end
      @(negedge clk);
    end
    chk($sformatf("valid_timeout%0d", k), 0, 1);
  endtask

  task automatic rand_run(input int k);
    int acc;
    for (int i = 0; i < 100; i++) begin
      send(k, 16'($urandom), 16'($urandom), acc);
    end
    for (int n = 0; n < 2000; n++) begin
      if (exp_q[k].size() == 0) break;
      @(negedge clk);
    end
    rand_done[k] = 1'b1;
    chk($sformatf("drain%0d", k), exp_q[k].size(), 0);
  endtask

  task automatic rand_ready(input int k);
    while (!rand_done[k]) begin
      out_ready_s[k] = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    out_ready_s[k] = 1'b1;
  endtask

  // Every output transfer is scored against the queued model result.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_mon
      always @(negedge clk) begin
        #1;
        if (!rst && out_valid_s[gi] && out_ready_s[gi]) begin
          if (exp_q[gi].size() == 0) begin
            chk($sformatf("spurious%0d", gi), 1, 0);
          end else begin
            $display("xfer k=%0d out=%h", gi, out_of(gi));
            chk($sformatf("xfer%0d", gi), out_of(gi), exp_q[gi].pop_front());
          end
        end
      end
    end
  endgenerate

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int lat;
    rst         = 1'b1;
    in_valid_s  = '0;
    out_ready_s = '1;
    rand_done   = '0;
    for (int k = 0; k < 4; k++) begin
      a_s[k] = '0;
      b_s[k] = '0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rst_in_ready%0d", k), int'(in_ready_s[k]), 0);
      chk($sformatf("rst_out_valid%0d", k), int'(out_valid_s[k]), 0);
      chk($sformatf("rst_out%0d", k), out_of(k), 0);
    end
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("idle_in_ready%0d", k), int'(in_ready_s[k]), 1);
    end

    // Basic unsigned, then backpressure with a competing input request.
    out_ready_s[0] = 1'b0;
    send(0, 16'h4321, 16'h1111, acc);
    wait_valid(0, acc, lat);
    chk("basic_latency", lat, 4);
    chk("basic_out", out_of(0), 'h00A);
    in_valid_s[0] = 1'b1;
    a_s[0] = 16'hFFFF;
    b_s[0] = 16'h2222;
    repeat (5) begin
      @(negedge clk);
      chk("bp_out", out_of(0), 'h00A);
      chk("bp_valid", int'(out_valid_s[0]), 1);
      chk("bp_in_ready", int'(in_ready_s[0]), 0);
    end
    out_ready_s[0] = 1'b1;
    in_valid_s[0]  = 1'b0;
    @(negedge clk);
    chk("ready_return", int'(in_ready_s[0]), 1);
    chk("valid_drop", int'(out_valid_s[0]), 0);

    // Width and wrap.
    send(0, 16'hFFFF, 16'hFFFF, acc);
    wait_valid(0, acc, lat);
    chk("wrap10", out_of(0), 'h384);
    send(1, 16'hFFFF, 16'hFFFF, acc);
    wait_valid(1, acc, lat);
    chk("wrap8", out_of(1), 'h84);

    // Signed.
    send(2, 16'hFFFF, 16'h7777, acc);
    wait_valid(2, acc, lat);
    chk("signed_out", out_of(2), 'h3E4);

    // Parallel lanes.
    send(3, 16'h4321, 16'h1111, acc);
    wait_valid(3, acc, lat);
    chk("par_latency", lat, 1);
    chk("par_out", out_of(3), 'h00A);
    @(negedge clk);

    // Reset two cycles after acceptance.
    send(0, 16'h5678, 16'h9ABC, acc);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_out", out_of(0), 0);
    chk("midrst_valid", int'(out_valid_s[0]), 0);
    chk("midrst_in_ready", int'(in_ready_s[0]), 0);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) exp_q[k].delete();
    @(negedge clk);
    chk("postrst_in_ready", int'(in_ready_s[0]), 1);
    repeat (5) @(negedge clk);
    chk("postrst_no_valid", int'(out_valid_s[0]), 0);
    send(0, 16'h4321, 16'h1111, acc);
    wait_valid(0, acc, lat);
    chk("postrst_out", out_of(0), 'h00A);
    @(negedge clk);

    // Random back-to-back traffic on all configurations with random out_ready.
    fork
      rand_run(0);
      rand_run(1);
      rand_run(2);
      rand_run(3);
      rand_ready(0);
      rand_ready(1);
      rand_ready(2);
      rand_ready(3);
    join
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
